moore_seq_detector_param: RTL
=============================

Name: moore_seq_detector_param

Overview:
- Parametrised, run-time programmable Moore serial pattern detector; successor to the fixed 1101 detector.
- Samples one serial bit per qualified clock.
- Asserts a registered match output when the last cfg_len bits equal the programmed pattern.
- Selectable overlapping/non-overlapping detection, plus a saturating match counter for status readout.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(PAT_W+1), width of the length field.
- CNT_W, 16, width of the match counter.
- RST_PATTERN, 8'b0000_1101, pattern loaded at reset (1101, length 4).
- RST_LEN, 4, pattern length at reset.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- x  input  1  serial data bit.
- x_valid  input  1  x is sampled on this edge only when high.
- cfg_load  input  1  one-cycle strobe: capture cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  input  PAT_W  pattern. Bit [len-1] is the first bit in time; bit [0] is the last.
- cfg_len  input  LEN_W  active pattern length, 1..PAT_W.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_count.
- y  output  1  Moore match flag, registered.
- match_count  output  CNT_W  saturating count of matches.
- armed  output  1  at least len valid bits received since last flush.

Behaviour:
- Reset (async, reset_n=0):
  - hist=0, fill=0, y=0, match_count=0, armed=0.
  - pat=RST_PATTERN, len=RST_LEN, overlap=1.
  - No output glitches after release.
- State:
  - hist[PAT_W-1:0] shift register; newest bit at hist[0].
  - fill: valid-bit count since last flush, saturating at PAT_W.
- Length clamp on load: cfg_len=0 loads len=1; cfg_len>PAT_W loads len=PAT_W.
- Accepting edge (x_valid=1, cfg_load=0):
  - nh={hist[PAT_W-2:0],x}; nf=min(fill+1,PAT_W).
  - hit = (nf>=len) && (nh[len-1:0]==pat[len-1:0]).
  - hist<=nh; y<=hit.
  - If hit && !overlap: fill<=0. Otherwise fill<=nf.
- Non-accepting edge (x_valid=0, cfg_load=0): hist and fill hold; y<=0. y is high for exactly one cycle per match.
- Latency: y is high during the clock cycle after the edge that sampled the completing bit. It depends only on registered state (Moore).
- armed = (fill>=len), combinational from registers.
- Overlap: after a match, the suffix of the matched bits is reused. Example: 1101101 with pat 1101 gives 2 matches with overlap=1 and 1 match with overlap=0.
- Counter:
  - On hit, match_count increments and saturates at all ones (no wrap).
  - cnt_clr=1 forces match_count<=0 and wins over a simultaneous hit. y still asserts for that hit.
- cfg_load=1:
  - Captures pat, clamped len and overlap.
  - Flushes hist=0, fill=0, y<=0.
  - A bit presented with x_valid in the same cycle is discarded.
  - match_count is unaffected.
  - New config takes effect from the next accepting edge.
- Reset mid-sequence: partial match lost; detection restarts from fill=0 after release. Configuration returns to reset values.
- x is don't-care when x_valid=0.

Test Plan:
- Reset defaults: release reset, stream x=1,1,1,0,1 (x_valid=1 every cycle) -> y pulses once, the cycle after the 5th bit; match_count=1; armed=1 from the 4th bit on.
- Overlap mode: defaults, stream 1,1,0,1,1,0,1 -> y high after bits 4 and 7; match_count=2. Repeat after cfg_load with overlap=0, len=4, pat=1101 -> y only after bit 4; count increments by 1.
- x_valid gaps: stream 1,1,0,1 with x_valid=0 idle cycles inserted between every bit -> single y pulse one cycle after the final valid bit; y low during idle cycles; hist unchanged across gaps.
- Reprogram/clamp:
  - cfg_load pat=8'b1010_0111, len=8, then stream 10100111 -> match.
  - cfg_load len=0 -> len=1; stream 1,1,1 with pat[0]=1 -> 3 consecutive y pulses.
  - cfg_load asserted with x_valid=1 -> that bit is ignored; fill=0.
- Saturation/clear: CNT_W=2, 5 matches -> match_count sticks at 3. cnt_clr coincident with a hit -> count=0 and y=1.
- Async reset mid-operation: assert reset_n=0 between clock edges after 3 bits of 1101 -> y=0 and count=0 immediately. After release, the full 4-bit pattern is required before the next y.

Source files
------------

// File: rtl/moore_seq_detector_param.sv
// Programmable Moore serial pattern detector with overlap control and match counter.
// Ports: clk, reset_n, x/x_valid serial in, cfg_* load, cnt_clr; y, match_count, armed out.
module moore_seq_detector_param #(
  parameter int                PAT_W       = 8,
  parameter int                LEN_W       = $clog2(PAT_W + 1),
  parameter int                CNT_W       = 16,
  parameter logic [PAT_W-1:0]  RST_PATTERN = PAT_W'(8'b0000_1101),
  parameter int                RST_LEN     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(RST_LEN);

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [PAT_W-1:0] hist_q;
  logic [LEN_W-1:0] fill_q;
  logic             y_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic [PAT_W-1:0] nh;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] nf;
  logic [LEN_W-1:0] len_c;
  logic             hit;

  assign accept = x_valid & ~cfg_load;

  always_comb begin
    nh = {hist_q[PAT_W-2:0], x};
    nf = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_ONE;
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
    // only the youngest len bits take part in the compare
    hit = (nf >= len_q) && (((nh ^ pat_q) & mask) == '0);
  end

  always_comb begin
    len_c = cfg_len;
    unique case (1'b1)
      (cfg_len == '0):     len_c = LEN_ONE;
      (cfg_len > LEN_MAX): len_c = LEN_MAX;
      default:             len_c = cfg_len;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q <= RST_PATTERN;
      len_q <= LEN_RST;
      ovl_q <= 1'b1;
    end else if (cfg_load) begin
      pat_q <= cfg_pattern;
      len_q <= len_c;
      ovl_q <= cfg_overlap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else begin
      unique case (1'b1)
        cfg_load: begin
          hist_q <= '0;
          fill_q <= '0;
          y_q    <= 1'b0;
        end
        accept: begin
          hist_q <= nh;
          y_q    <= hit;
          // non-overlap: matched bits cannot seed the next match
          fill_q <= (hit && !ovl_q) ? '0 : nf;
        end
        default: begin
          y_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (accept && hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign y           = y_q;
  assign match_count = cnt_q;
  assign armed       = (fill_q >= len_q);

endmodule
